// File: rtl/hack_data_mem.sv
// Data-side memory responder for a Hack-style CPU: register-file RAM plus
// memory-mapped output port, synchronized input port, cycle counter and status.
module hack_data_mem #(
    parameter int          DEPTH   = 16,
    parameter logic [14:0] IO_BASE = 15'h4000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [14:0] mem_addr_i,
    input  logic        mem_we_i,
    input  logic [15:0] mem_data_i,
    output logic [15:0] mem_data_o,
    input  logic [15:0] in_port_i,
    output logic [15:0] out_port_o,
    output logic        out_strobe_o,
    output logic [15:0] cycle_count_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [14:0] DEPTH_A = 15'(DEPTH);
    localparam logic [14:0] OUT_A   = IO_BASE;
    localparam logic [14:0] IN_A    = IO_BASE + 15'd1;
    localparam logic [14:0] CNT_A   = IO_BASE + 15'd2;
    localparam logic [14:0] STAT_A  = IO_BASE + 15'd3;

    logic [15:0]   r_ram [DEPTH];
    logic [15:0]   r_outPort;
    logic          r_outStrobe;
    logic [15:0]   r_cycleCount;
    logic [15:0]   r_sync1;
    logic [15:0]   r_sync2;

    logic          w_ramHit;
    logic [AW-1:0] w_ramIdx;
    logic          w_outWrite;
    logic          w_cntWrite;
    logic [15:0]   w_readData;

    // Full 15-bit decode: addresses between DEPTH and IO_BASE never alias into RAM.
    assign w_ramHit   = (mem_addr_i < DEPTH_A);
    assign w_ramIdx   = mem_addr_i[AW-1:0];
    assign w_outWrite = mem_we_i && (mem_addr_i == OUT_A);
    assign w_cntWrite = mem_we_i && (mem_addr_i == CNT_A);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ram[i] <= '0;
            end
        end else if (mem_we_i && w_ramHit) begin
            r_ram[w_ramIdx] <= mem_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outPort    <= '0;
            r_outStrobe  <= 1'b0;
            r_cycleCount <= '0;
            r_sync1      <= '0;
            r_sync2      <= '0;
        end else begin
            r_outStrobe <= w_outWrite;
            if (w_outWrite) begin
                r_outPort <= mem_data_i;
            end
            // A CPU load of the counter wins over the free-running increment.
            if (w_cntWrite) begin
                r_cycleCount <= mem_data_i;
            end else begin
                r_cycleCount <= r_cycleCount + 16'd1;
            end
            r_sync1 <= in_port_i;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_readData = 16'h0000;
        if (w_ramHit) begin
            w_readData = r_ram[w_ramIdx];
        end else begin
            unique case (mem_addr_i)
                OUT_A:   w_readData = r_outPort;
                IN_A:    w_readData = r_sync2;
                CNT_A:   w_readData = r_cycleCount;
                STAT_A:  w_readData = {15'b0, r_outStrobe};
                default: w_readData = 16'h0000;
            endcase
        end
    end

    assign mem_data_o    = w_readData;
    assign out_port_o    = r_outPort;
    assign out_strobe_o  = r_outStrobe;
    assign cycle_count_o = r_cycleCount;

endmodule

// File: tb/tb_hack_data_mem.sv
// Directed-vector bench for hack_data_mem: each table row is one CPU cycle,
// with expected outputs as seen before that cycle's rising edge.
module tb_hack_data_mem;

    typedef struct {
        logic        rstN;
        logic [14:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] inPort;
        logic [15:0] expRd;
        logic [15:0] expOut;
        logic        expStb;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [14:0] mem_addr_i;
    logic        mem_we_i;
    logic [15:0] mem_data_i;
    logic [15:0] mem_data_o;
    logic [15:0] in_port_i;
    logic [15:0] out_port_o;
    logic        out_strobe_o;
    logic [15:0] cycle_count_o;

    int          checks;
    int          errors;
    logic [15:0] expCnt;
    vec_t        vecs[$];

    hack_data_mem #(.DEPTH(16), .IO_BASE(15'h4000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_addr_i    (mem_addr_i),
        .mem_we_i      (mem_we_i),
        .mem_data_i    (mem_data_i),
        .mem_data_o    (mem_data_o),
        .in_port_i     (in_port_i),
        .out_port_o    (out_port_o),
        .out_strobe_o  (out_strobe_o),
        .cycle_count_o (cycle_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void addVec(input logic rstN, input logic [14:0] addr, input logic we,
                                   input logic [15:0] wdata, input logic [15:0] inPort,
                                   input logic [15:0] expRd, input logic [15:0] expOut,
                                   input logic expStb);
        vec_t v;
        v.rstN = rstN; v.addr = addr; v.we = we; v.wdata = wdata; v.inPort = inPort;
        v.expRd = expRd; v.expOut = expOut; v.expStb = expStb;
        vecs.push_back(v);
    endfunction

    // Drive one cycle, check combinational/registered outputs, then clock it.
    task automatic applyStimulus(input int idx, input vec_t v);
        rst_n      = v.rstN;
        mem_addr_i = v.addr;
        mem_we_i   = v.we;
        mem_data_i = v.wdata;
        in_port_i  = v.inPort;
        #1;
        checkOutput($sformatf("row%0d rdata", idx), mem_data_o, v.expRd);
        checkOutput($sformatf("row%0d out_port", idx), out_port_o, v.expOut);
        checkOutput($sformatf("row%0d strobe", idx), {15'b0, out_strobe_o}, {15'b0, v.expStb});
        checkOutput($sformatf("row%0d count", idx), cycle_count_o, expCnt);
        if (!v.rstN) expCnt = 16'h0000;
        else if (v.we && v.addr == 15'h4002) expCnt = v.wdata;
        else expCnt = expCnt + 16'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        expCnt = 16'h0000;
        rst_n      = 1'b0;
        mem_addr_i = 15'd0;
        mem_we_i   = 1'b0;
        mem_data_i = 16'h0000;
        in_port_i  = 16'h0000;

        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        mem_addr_i = 15'd4;
        #1;
        checkOutput("reset rdata", mem_data_o, 16'h0000);
        checkOutput("reset out_port", out_port_o, 16'h0000);
        checkOutput("reset strobe", {15'b0, out_strobe_o}, 16'h0000);
        checkOutput("reset count", cycle_count_o, 16'h0000);

        //     rstN addr      we wdata    inPort   expRd    expOut   expStb
        addVec(1, 15'd3,    1, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(1, 15'd3,    0, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 0);
        addVec(1, 15'd4,    0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(1, 15'h4000, 1, 16'h00A5, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(1, 15'h4000, 0, 16'h0000, 16'h0000, 16'h00A5, 16'h00A5, 1);
        addVec(1, 15'h4003, 0, 16'h0000, 16'h0000, 16'h0000, 16'h00A5, 0);
        addVec(1, 15'h4000, 1, 16'h0011, 16'h0000, 16'h00A5, 16'h00A5, 0);
        addVec(1, 15'h4000, 1, 16'h0022, 16'h0000, 16'h0011, 16'h0011, 1);
        addVec(1, 15'h4003, 0, 16'h0000, 16'h0000, 16'h0001, 16'h0022, 1);
        addVec(1, 15'h4003, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0022, 0);
        addVec(1, 15'h4001, 0, 16'h0000, 16'h1234, 16'h0000, 16'h0022, 0);
        addVec(1, 15'h4001, 0, 16'h0000, 16'h1234, 16'h0000, 16'h0022, 0);
        addVec(1, 15'h4001, 0, 16'h0000, 16'h1234, 16'h1234, 16'h0022, 0);
        addVec(1, 15'h4001, 1, 16'hFFFF, 16'h1234, 16'h1234, 16'h0022, 0);
        addVec(1, 15'h4001, 0, 16'h0000, 16'h1234, 16'h1234, 16'h0022, 0);
        addVec(1, 15'h4002, 1, 16'hFFFE, 16'h1234, 16'h000F, 16'h0022, 0);
        addVec(1, 15'h4002, 0, 16'h0000, 16'h1234, 16'hFFFE, 16'h0022, 0);
        addVec(1, 15'h4002, 0, 16'h0000, 16'h1234, 16'hFFFF, 16'h0022, 0);
        addVec(1, 15'h4002, 0, 16'h0000, 16'h1234, 16'h0000, 16'h0022, 0);
        addVec(1, 15'h4002, 0, 16'h0000, 16'h1234, 16'h0001, 16'h0022, 0);
        addVec(0, 15'h4002, 0, 16'h0000, 16'h0000, 16'h0002, 16'h0022, 0);
        addVec(1, 15'h4002, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(1, 15'd3,    0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(1, 15'd0,    1, 16'h1111, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(1, 15'd16,   1, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(1, 15'h4004, 1, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(1, 15'd16,   0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(1, 15'h4004, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(1, 15'd0,    0, 16'h0000, 16'h0000, 16'h1111, 16'h0000, 0);
        addVec(1, 15'h4003, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(1, 15'd15,   1, 16'hFACE, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(1, 15'd15,   0, 16'h0000, 16'h0000, 16'hFACE, 16'h0000, 0);
        addVec(1, 15'd2,    1, 16'h1357, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(1, 15'd2,    0, 16'h0000, 16'h0000, 16'h1357, 16'h0000, 0);
        addVec(0, 15'd2,    1, 16'h7777, 16'h0000, 16'h1357, 16'h0000, 0);
        addVec(1, 15'd2,    0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(1, 15'd15,   0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);

        foreach (vecs[i]) begin
            applyStimulus(i, vecs[i]);
        end

        // Same-cycle read returns the old word; a write under reset is dropped.
        rst_n      = 1'b1;
        mem_addr_i = 15'd5;
        mem_we_i   = 1'b1;
        mem_data_i = 16'hC0DE;
        #1;
        checkOutput("same-cycle rdata", mem_data_o, 16'h0000);
        @(posedge clk);
        #1;
        mem_we_i = 1'b0;
        #1;
        checkOutput("next-cycle rdata", mem_data_o, 16'hC0DE);
        rst_n      = 1'b0;
        mem_addr_i = 15'h4000;
        mem_we_i   = 1'b1;
        mem_data_i = 16'h00FF;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        mem_we_i = 1'b0;
        #1;
        checkOutput("reset-write out_port", out_port_o, 16'h0000);
        checkOutput("reset-write strobe", {15'b0, out_strobe_o}, 16'h0000);
        mem_addr_i = 15'd5;
        #1;
        checkOutput("reset-cleared ram5", mem_data_o, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hack_data_mem.md
Name: hack_data_mem

Overview:
- Data-side responder for the Hack-style CPU memory port. The CPU drives a 15-bit address, write-enable and 16-bit write data, and expects read data in the same cycle.
- The block provides a small register-file RAM plus memory-mapped I/O:
  - output port register with write strobe
  - synchronized input port
  - free-running cycle counter
- It sits between the CPU core and the chip pins, so programs can do I/O through ordinary M reads and writes.

Parameters:
- DEPTH, 16, number of 16-bit RAM words, mapped at addresses 0..DEPTH-1. Power of two, 2..256.
- IO_BASE, 15'h4000, base address of the I/O register window (4 words).

Ports:
- clk  input  1  system clock; all state changes on posedge clk
- rst_n  input  1  synchronous active-low reset
- mem_addr_i  input  15  address from CPU
- mem_we_i  input  1  write enable from CPU
- mem_data_i  input  16  write data from CPU
- mem_data_o  output  16  read data to CPU, combinational from mem_addr_i and current state
- in_port_i  input  16  external input pins, asynchronous
- out_port_o  output  16  output port register
- out_strobe_o  output  1  one-cycle pulse after each write to OUT
- cycle_count_o  output  16  current cycle counter value, for debug

Behaviour:
- Reset:
  - Reset is synchronous: applied only on posedge clk while rst_n=0.
  - It clears all RAM words, out_port_o, out_strobe_o, cycle counter and both input synchronizer stages to 0.
  - Writes presented while rst_n=0 are ignored.
- Address map (a = mem_addr_i):
  - RAM: a < DEPTH. Read returns ram[a]. Write stores mem_data_i into ram[a] at the next posedge.
  - OUT: a = IO_BASE+0. Read returns out_port_o. Write loads out_port_o and sets out_strobe_o=1 for exactly the following cycle.
  - IN: a = IO_BASE+1. Read returns the synchronized input (sync2). Writes are ignored.
  - CNT: a = IO_BASE+2. Read returns the counter. Write loads the counter with mem_data_i; that write takes priority over the increment in the same cycle.
  - STAT: a = IO_BASE+3. Read returns {15'b0, out_strobe_o}. Writes are ignored.
  - Any other address: read returns 16'h0000, write has no effect, no error signalled.
- Read latency: zero cycles. mem_data_o is combinational so the single-cycle CPU can use it in the same instruction.
- Read-after-write: a read issued one cycle after a write to the same location returns the new value. A read in the same cycle as the write returns the old value.
- Input synchronizer: in_port_i passes through two flops, sync1 then sync2, with no reset bypass. A change on in_port_i is visible at IN reads 2 posedges later.
- Cycle counter:
  - Increments by 1 every posedge when rst_n=1 and there is no CNT write.
  - Wraps 16'hFFFF to 16'h0000 with no flag.
- Output strobe:
  - out_strobe_o is registered: 1 in the cycle after a write to OUT, otherwise 0.
  - Back-to-back OUT writes hold it high for consecutive cycles, one per write.
  - out_port_o changes on the same edge the strobe rises.
- Address decode uses the full 15 bits. RAM addresses in DEPTH..IO_BASE-1 are unmapped and do not alias.
- No internal FSM beyond the registers above. There is no back-pressure, and every access completes in one cycle.

Test Plan:
- Reset and RAM write/read:
  - Stimulus: hold rst_n=0 for 2 cycles, then release. Write 16'hBEEF to addr 3, then read addr 3 next cycle.
  - Required: mem_data_o=16'hBEEF; addr 4 reads 0; out_port_o=0 after reset.
- Output port:
  - Stimulus: write 16'h00A5 to 15'h4000.
  - Required: next cycle out_port_o=16'h00A5 and out_strobe_o=1; the cycle after, strobe=0. Two consecutive writes give a 2-cycle strobe.
- Input sync:
  - Stimulus: set in_port_i=16'h1234 while reading 15'h4001 every cycle.
  - Required: reads return the old value for 2 edges, then 16'h1234. Writing 16'hFFFF to 15'h4001 changes nothing.
- Counter:
  - Stimulus: write 16'hFFFE to 15'h4002, then read each cycle.
  - Required: reads show 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001. Asserting rst_n=0 mid-count gives 0 after the edge.
- Unmapped and bounds:
  - Stimulus: with DEPTH=16, write 16'h5555 to addr 16 and to 15'h4004.
  - Required: both read 0; RAM[0] is unchanged (no aliasing); STAT reads 0 when idle.
- Reset mid-write:
  - Stimulus: assert mem_we_i to addr 2 with data 16'h7777 in the same cycle as rst_n=0.
  - Required: ram[2]=0 afterwards.
